fp_align_ctrl: RTL and testbench

Alignment controller for the FP ALU add/sub path: the initiator that drives the `shift_register` block. It takes two unpacked operands and compares their exponents. It then commands the shifter to right-shift the smaller operand's mantissa by the exponent difference, waits for `done`, and presents both mantissas aligned to a common exponent.

---
 rtl/fp_alu_pkg.sv | 24 ++
 rtl/fp_align_ctrl_exp_compare.sv | 28 ++
 rtl/fp_align_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_fp_align_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU add/sub path: alignment FSM states and
// width helpers derived from the mantissa size.
package fp_alu_pkg;

    // Alignment controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } align_state_t;

    // Carried mantissa width: stored fraction plus the hidden 1
    function automatic int mant_width(input int mantissa_size);
        return mantissa_size + 1;
    endfunction

    // Number of WAIT cycles allowed before the shifter is declared stuck
    function automatic int wd_limit(input int mantissa_size);
        return mantissa_size + 4;
    endfunction

endpackage

// File: rtl/fp_align_ctrl_exp_compare.sv
// exp_compare: combinational exponent/mantissa comparison for operand
// alignment. Reports which operand is smaller, the exponent distance and
// whether that distance pushes every mantissa bit out (flush).
module exp_compare import fp_alu_pkg::*; #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic [Exponent_Size-1:0] a_exponent,
    input  logic [Exponent_Size-1:0] b_exponent,
    input  logic [Mantissa_Size:0]   a_mantissa,
    input  logic [Mantissa_Size:0]   b_mantissa,
    output logic                     swapped,
    output logic [Exponent_Size-1:0] diff,
    output logic                     flush
);

    // Any distance of at least the carried width shifts out the whole mantissa
    localparam logic [Exponent_Size-1:0] FLUSH_MIN = Exponent_Size'(mant_width(Mantissa_Size));

    // B wins on a larger exponent, or on a tie by the larger mantissa
    always_comb begin
        swapped = (b_exponent > a_exponent) ||
                  ((b_exponent == a_exponent) && (b_mantissa > a_mantissa));
        diff    = swapped ? (b_exponent - a_exponent) : (a_exponent - b_exponent);
        flush   = (diff >= FLUSH_MIN);
    end

endmodule

// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: alignment controller for the FP add/sub path. Compares the
// two operand exponents, drives an external right shifter to align the
// smaller mantissa, and presents both mantissas at the common exponent.
// Optional feature: define ALIGN_STICKY_EN to add the `sticky` output (OR of
// the bits shifted out of the smaller mantissa).
module fp_align_ctrl import fp_alu_pkg::*; #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [Exponent_Size-1:0] a_exponent,
    input  logic [Exponent_Size-1:0] b_exponent,
    input  logic [Mantissa_Size:0]   a_mantissa,
    input  logic [Mantissa_Size:0]   b_mantissa,
    output logic                     sh_enable,
    output logic                     sh_load,
    output logic                     sh_direction,
    output logic [Exponent_Size-1:0] sh_no_of_shifts,
    output logic [Mantissa_Size:0]   sh_mantissa,
    output logic [Exponent_Size-1:0] sh_exponent,
    input  logic                     sh_done,
    input  logic [Mantissa_Size:0]   sh_result,
    output logic                     busy,
    output logic                     valid,
    output logic [Mantissa_Size:0]   big_mantissa,
    output logic [Mantissa_Size:0]   small_mantissa,
    output logic [Exponent_Size-1:0] common_exponent,
    output logic                     swapped,
    output logic                     timeout
`ifdef ALIGN_STICKY_EN
    ,
    output logic                     sticky
`endif
);

    localparam int MW       = mant_width(Mantissa_Size);
    localparam int WD_LIMIT = wd_limit(Mantissa_Size);
    localparam int WD_W     = $clog2(WD_LIMIT);
    // Counter value seen in the last permitted WAIT cycle
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    align_state_t state, state_next;

    // Operands captured on the accepted start
    logic [Exponent_Size-1:0] a_exp_q, b_exp_q;
    logic [MW-1:0]            a_mant_q, b_mant_q;

    // Comparison results and the big/small operand selection
    logic                     cmp_swapped;
    logic [Exponent_Size-1:0] cmp_diff;
    logic                     cmp_flush;
    logic                     cmp_bypass;
    logic [MW-1:0]            sel_big_mant, sel_small_mant;
    logic [Exponent_Size-1:0] sel_big_exp, sel_small_exp;

    // Watchdog on the shifter handshake
    logic [WD_W-1:0]          wd_cnt_q;
    logic                     wd_expired;

`ifdef ALIGN_STICKY_EN
    // OR of the mantissa bits that a right shift by `sh` discards; a shift
    // of the full width or more naturally covers every bit.
    function automatic logic calc_sticky(input logic [MW-1:0] mant,
                                         input logic [Exponent_Size-1:0] sh);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < MW; i++) begin
            if (Exponent_Size'(i) < sh) begin
                acc = acc | mant[i];
            end
        end
        return acc;
    endfunction
`endif

    exp_compare #(
        .Mantissa_Size (Mantissa_Size),
        .Exponent_Size (Exponent_Size)
    ) u_exp_compare (
        .a_exponent (a_exp_q),
        .b_exponent (b_exp_q),
        .a_mantissa (a_mant_q),
        .b_mantissa (b_mant_q),
        .swapped    (cmp_swapped),
        .diff       (cmp_diff),
        .flush      (cmp_flush)
    );

    assign sel_big_mant   = cmp_swapped ? b_mant_q : a_mant_q;
    assign sel_small_mant = cmp_swapped ? a_mant_q : b_mant_q;
    assign sel_big_exp    = cmp_swapped ? b_exp_q  : a_exp_q;
    assign sel_small_exp  = cmp_swapped ? a_exp_q  : b_exp_q;
    // Equal exponents or a full flush need no shifter pass
    assign cmp_bypass     = (cmp_diff == '0) || cmp_flush;
    assign wd_expired     = (wd_cnt_q == WD_LAST);

    // State register; reset returns to IDLE at once, aborting any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded strobes
    always_comb begin
        state_next = state;
        sh_enable  = 1'b1;
        sh_load    = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                sh_enable = 1'b0;
                if (start) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                busy       = 1'b1;
                state_next = cmp_bypass ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                sh_load    = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (sh_done || wd_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                valid      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                sh_enable  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture and shifter direction; direction latches to right on first use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_exp_q      <= '0;
            b_exp_q      <= '0;
            a_mant_q     <= '0;
            b_mant_q     <= '0;
            sh_direction <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            a_exp_q      <= a_exponent;
            b_exp_q      <= b_exponent;
            a_mant_q     <= a_mantissa;
            b_mant_q     <= b_mantissa;
            sh_direction <= 1'b1;
        end
    end

    // Shifter command: loaded in COMPARE so it is stable throughout LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_no_of_shifts <= '0;
            sh_mantissa     <= '0;
            sh_exponent     <= '0;
        end else if ((state == ST_COMPARE) && !cmp_bypass) begin
            sh_no_of_shifts <= cmp_diff;
            sh_mantissa     <= sel_small_mant;
            sh_exponent     <= sel_small_exp;
        end
    end

    // Watchdog: cleared in COMPARE, counts each WAIT cycle without done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (state == ST_COMPARE) begin
            wd_cnt_q <= '0;
        end else if ((state == ST_WAIT) && !sh_done && !wd_expired) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // Aligned results; held from DONE until the next operation rewrites them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            big_mantissa    <= '0;
            small_mantissa  <= '0;
            common_exponent <= '0;
            swapped         <= 1'b0;
        end else begin
            case (state)
                ST_COMPARE: begin
                    big_mantissa    <= sel_big_mant;
                    common_exponent <= sel_big_exp;
                    swapped         <= cmp_swapped;
                    if (cmp_diff == '0) begin
                        small_mantissa <= sel_small_mant;
                    end else if (cmp_flush) begin
                        small_mantissa <= '0;
                    end
                end
                ST_WAIT: begin
                    if (sh_done) begin
                        small_mantissa <= sh_result;
                    end else if (wd_expired) begin
                        small_mantissa <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky timeout flag: cleared on an accepted start, set when the shifter never answers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            timeout <= 1'b0;
        end else if ((state == ST_WAIT) && !sh_done && wd_expired) begin
            timeout <= 1'b1;
        end
    end

`ifdef ALIGN_STICKY_EN
    // Sticky bit from the captured small mantissa; a stuck shifter forces it high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (state == ST_COMPARE) begin
            sticky <= calc_sticky(sel_small_mant, cmp_diff);
        end else if ((state == ST_WAIT) && !sh_done && wd_expired) begin
            sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Testbench for fp_align_ctrl with a behavioural right shifter of
// programmable latency. Build with ALIGN_STICKY_EN to also check `sticky`.
module tb_fp_align_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_exponent, b_exponent;
    logic [23:0] a_mantissa, b_mantissa;
    logic        sh_enable, sh_load, sh_direction;
    logic [7:0]  sh_no_of_shifts, sh_exponent;
    logic [23:0] sh_mantissa;
    logic        sh_done;
    logic [23:0] sh_result;
    logic        busy, valid, swapped, timeout;
    logic [23:0] big_mantissa, small_mantissa;
    logic [7:0]  common_exponent;
`ifdef ALIGN_STICKY_EN
    logic        sticky;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_align_ctrl #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .a_exponent      (a_exponent),
        .b_exponent      (b_exponent),
        .a_mantissa      (a_mantissa),
        .b_mantissa      (b_mantissa),
        .sh_enable       (sh_enable),
        .sh_load         (sh_load),
        .sh_direction    (sh_direction),
        .sh_no_of_shifts (sh_no_of_shifts),
        .sh_mantissa     (sh_mantissa),
        .sh_exponent     (sh_exponent),
        .sh_done         (sh_done),
        .sh_result       (sh_result),
        .busy            (busy),
        .valid           (valid),
        .big_mantissa    (big_mantissa),
        .small_mantissa  (small_mantissa),
        .common_exponent (common_exponent),
        .swapped         (swapped),
        .timeout         (timeout)
`ifdef ALIGN_STICKY_EN
        ,
        .sticky          (sticky)
`endif
    );

    // Behavioural shifter: done arrives in the sh_lat-th cycle after the load
    int          sh_lat = 1;
    bit          sh_tie = 1'b0;
    logic        sh_pend;
    int          sh_cnt;
    logic [23:0] sh_res_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_pend  <= 1'b0;
            sh_cnt   <= 0;
            sh_res_q <= '0;
        end else if (sh_enable && sh_load) begin
            sh_pend  <= 1'b1;
            sh_cnt   <= sh_lat;
            sh_res_q <= sh_mantissa >> sh_no_of_shifts;
        end else if (sh_pend) begin
            if (sh_cnt <= 1) sh_pend <= 1'b0;
            else             sh_cnt  <= sh_cnt - 1;
        end
    end

    assign sh_done   = sh_pend && (sh_cnt == 1) && !sh_tie;
    assign sh_result = sh_res_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl"}, 64'({sh_enable, sh_load, sh_direction, busy, valid, swapped, timeout,
                                 sh_no_of_shifts, sh_exponent, common_exponent}), 64'd0);
        chk({tag, " mants"}, 64'({big_mantissa, small_mantissa}), 64'd0);
        chk({tag, " sh_mant"}, 64'(sh_mantissa), 64'd0);
`ifdef ALIGN_STICKY_EN
        chk({tag, " sticky"}, 64'(sticky), 64'd0);
`endif
    endtask

    // Drive one operation and compare against the arithmetic reference model
    task automatic run_op(input logic [7:0] ae, input logic [23:0] am,
                          input logic [7:0] be, input logic [23:0] bm,
                          input int lat, input bit tie, input bit poke, input string tag);
        bit          sw;
        logic [7:0]  bexp, sexp, d;
        logic [23:0] bmant, smant, e_small;
        bit          e_stk, e_to;
        int          e_lat, e_loads;
        int          n, loads;
        bit          got, busy_ok;
        logic [7:0]  ld_n, ld_e;
        logic [23:0] ld_m;
        logic [23:0] o_big, o_small;
        logic [7:0]  o_ce;
        logic        o_sw, o_to;
`ifdef ALIGN_STICKY_EN
        logic        o_stk;
`endif
        // reference model
        sw    = (be > ae) || ((be == ae) && (bm > am));
        bexp  = sw ? be : ae;
        sexp  = sw ? ae : be;
        bmant = sw ? bm : am;
        smant = sw ? am : bm;
        d     = bexp - sexp;
        e_to = 1'b0; e_loads = 0;
        if (d == 0) begin
            e_small = smant; e_stk = 1'b0; e_lat = 3;
        end else if (d >= 24) begin
            e_small = '0; e_stk = (smant != 0); e_lat = 3;
        end else if (tie) begin
            e_small = '0; e_stk = 1'b1; e_to = 1'b1; e_lat = 4 + 27; e_loads = 1;
        end else begin
            e_small = smant >> d;
            e_stk   = ((smant & ((24'h1 << d) - 24'h1)) != 0);
            e_lat   = 4 + lat; e_loads = 1;
        end
        sh_lat = lat; sh_tie = tie;
        ld_n = '0; ld_m = '0; ld_e = '0;
        o_big = '0; o_small = '0; o_ce = '0; o_sw = 1'b0; o_to = 1'b0;
`ifdef ALIGN_STICKY_EN
        o_stk = 1'b0;
`endif
        @(negedge clk);
        a_exponent = ae; a_mantissa = am; b_exponent = be; b_mantissa = bm; start = 1'b1;
        n = 1; loads = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) begin
                start = 1'b1; a_exponent = ~ae; b_mantissa = ~bm;
            end else begin
                start = 1'b0;
            end
            if (n == 2) chk({tag, " to_clr"}, 64'(timeout), 64'd0);
            if (sh_load) begin
                loads++; ld_n = sh_no_of_shifts; ld_m = sh_mantissa; ld_e = sh_exponent;
            end
            if (valid) begin
                got = 1'b1;
                if (busy) busy_ok = 1'b0;
                o_big = big_mantissa; o_small = small_mantissa; o_ce = common_exponent;
                o_sw = swapped; o_to = timeout;
`ifdef ALIGN_STICKY_EN
                o_stk = sticky;
`endif
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0; a_exponent = ae; b_mantissa = bm;
        chk({tag, " latency"}, 64'(n), 64'(e_lat));
        chk({tag, " busy"}, 64'(busy_ok), 64'd1);
        chk({tag, " loads"}, 64'(loads), 64'(e_loads));
        chk({tag, " big"}, 64'(o_big), 64'(bmant));
        chk({tag, " small"}, 64'(o_small), 64'(e_small));
        chk({tag, " cexp"}, 64'(o_ce), 64'(bexp));
        chk({tag, " swapped"}, 64'(o_sw), 64'(sw));
        chk({tag, " timeout"}, 64'(o_to), 64'(e_to));
`ifdef ALIGN_STICKY_EN
        chk({tag, " sticky"}, 64'(o_stk), 64'(e_stk));
`endif
        if (e_loads != 0) begin
            chk({tag, " ld_shifts"}, 64'(ld_n), 64'(d));
            chk({tag, " ld_mant"}, 64'(ld_m), 64'(smant));
            chk({tag, " ld_exp"}, 64'(ld_e), 64'(sexp));
        end
        @(negedge clk);
        chk({tag, " idle"}, 64'({valid, busy, sh_enable, sh_direction}), 64'b0001);
        chk({tag, " hold"}, 64'(small_mantissa), 64'(e_small));
    endtask

    // Global time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        int          nv;
        logic [7:0]  ae, be;
        logic [23:0] am, bm;
        int          t;

        rst_n = 1'b0; start = 1'b0;
        a_exponent = '0; b_exponent = '0; a_mantissa = '0; b_mantissa = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        run_op(8'd11, 24'h800000, 8'd6,  24'h6E2AE6, 2, 1'b0, 1'b0, "shift");
        run_op(8'd3,  24'h800001, 8'd4,  24'h9ABCDE, 1, 1'b0, 1'b0, "swap");
        run_op(8'd20, 24'hC00000, 8'd20, 24'hA00000, 3, 1'b0, 1'b0, "equal");
        run_op(8'd100,24'hF12345, 8'd50, 24'h876543, 2, 1'b0, 1'b0, "flush");
        run_op(8'd40, 24'h912345, 8'd64, 24'hFFFFFF, 2, 1'b0, 1'b0, "flush_sw");
        run_op(8'd30, 24'hABCDEF, 8'd7,  24'hFFFFFF, 4, 1'b0, 1'b0, "diff23");
        run_op(8'd11, 24'h800000, 8'd6,  24'h6E2AE6, 3, 1'b1, 1'b0, "watchdog");
        run_op(8'd11, 24'h800000, 8'd6,  24'h6E2AE6, 2, 1'b0, 1'b0, "after_wd");

        // Reset while the controller waits on a stuck shifter
        sh_lat = 3; sh_tie = 1'b1;
        @(negedge clk);
        a_exponent = 8'd11; a_mantissa = 24'h800000;
        b_exponent = 8'd6;  b_mantissa = 24'h6E2AE6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid pre_busy", 64'({busy, sh_enable}), 64'b11);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid async");
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rst_mid held");
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid || busy) nv++;
        end
        chk("rst_mid no_valid", 64'(nv), 64'd0);
        run_op(8'd9, 24'hC34567, 8'd12, 24'h812345, 2, 1'b0, 1'b1, "post_rst");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ae = 8'($urandom_range(0, 255));
            am = {1'b1, 23'($urandom)};
            bm = {1'b1, 23'($urandom)};
            case ($urandom_range(0, 3))
                0: begin
                    be = ae;
                    if ($urandom_range(0, 3) == 0) bm = am;
                end
                1, 2: begin
                    t = int'(ae) + int'($urandom_range(0, 30)) - 15;
                    if (t < 0) t = 0;
                    if (t > 255) t = 255;
                    be = 8'(t);
                end
                default: be = 8'($urandom_range(0, 255));
            endcase
            run_op(ae, am, be, bm, int'($urandom_range(1, 6)), (i % 10) == 7, (i % 7) == 3, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
